free_list: RTL and testbench
============================

Name: free_list

Overview:
- Physical-register free list with integrated retirement map (RRAT).
- Sits downstream of the ROB commit port. It consumes committed (ARN, PRN, reg_write) lanes and proc_nuke.
- It reclaims each overwritten physical register and supplies free PRNs to rename/dispatch.
- On a nuke it rebuilds the free list from the architectural map and exports the RRAT so the front-end RAT can be restored.

Parameters:
WAYS, `WAYS, superscalar width (dispatch and commit lanes)
PRF, `PRF, number of physical registers (power of two)
REGS, `REGS, number of architectural registers (32)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
alloc_req  in  WAYS  dispatch lane i consumes free_PRN[i]; set bits contiguous from lane 0
free_PRN  out  WAYS x $clog2(PRF)  candidate free PRNs, lane i = buffer[head+i]
free_valid  out  WAYS  lane i = (i < count) && !recovering
num_avail  out  $clog2(PRF)+1  current free count (0 while recovering)
commit_valid  in  WAYS  ROB valid_out (committing reg-writing instruction)
commit_ARN  in  WAYS x 5  ROB dest_ARN_out
commit_PRN  in  WAYS x $clog2(PRF)  ROB dest_PRN_out
proc_nuke  in  1  ROB mispredict flush
recovering  out  1  rebuild in progress; dispatch must stall
rrat_out  out  REGS x $clog2(PRF)  committed ARN->PRN map

Behaviour:
- State:
  - Circular buffer, depth PRF, with head, tail and count, each $clog2(PRF)+1 wide.
  - RRAT[REGS].
  - arch_used[PRF] bitmask, set when a PRN is mapped in the RRAT.
  - FSM {NORMAL, RECOVER}; scan counter $clog2(PRF)+1 bits.
- Reset (reset==0, asynchronous):
  - RRAT[i]=i; arch_used = PRNs 0..REGS-1.
  - Buffer holds REGS..PRF-1 in ascending order; head=0, tail=PRF-REGS, count=PRF-REGS.
  - FSM=NORMAL; recovering=0.
  - Resulting outputs: num_avail=PRF-REGS, free_PRN[i]=REGS+i, free_valid lanes follow from count.
- Allocation (NORMAL):
  - pops = popcount(alloc_req); head += pops; count -= pops.
  - alloc_req set beyond free_valid is illegal; the bench asserts on it.
  - Zero-cycle read: free_PRN is combinational from head.
  - PRNs pushed this cycle are not visible until the next cycle (no bypass).
- Commit reclaim (NORMAL, and also in the nuke cycle):
  - For each lane i with commit_valid[i], in lane order: old = PRN from the most recent earlier lane j<i with the same ARN, else RRAT[ARN].
  - Push old at tail+k, where k is its rank among valid lanes.
  - RRAT[ARN] <= commit_PRN; the last lane wins. arch_used: clear old, set new.
  - ARN 0 is treated like any other register.
- Count update: count_next = count - pops + pushes. Pointers wrap modulo PRF; count never exceeds PRF-REGS.
- proc_nuke (NORMAL only):
  - That cycle's commits are applied (RRAT and arch_used updated); that cycle's pops are ignored.
  - Next state: head=tail=count=0, scan=0, FSM=RECOVER.
- RECOVER:
  - Each cycle, if !arch_used[scan], push scan; scan += 1.
  - When scan reaches PRF-1 (processed that cycle), go to NORMAL.
  - recovering=1 for exactly PRF cycles, starting the cycle after the nuke.
  - free_valid=0 and num_avail=0 throughout.
  - alloc_req, commit_valid and proc_nuke are ignored; an assertion checks that commit_valid and proc_nuke stay 0.
  - Afterwards, count=PRF-REGS and the buffer holds the free PRNs in ascending order.
- rrat_out is the registered RRAT. It is valid the cycle after the nuke and stable throughout RECOVER.
- reset asserted mid-RECOVER: immediate return to the reset state.

Decomposition:
- Shared package:
  - PRN/ARN index typedefs (prn_t, arn_t).
  - fl_state_e enum {NORMAL, RECOVER}.
  - PRF/REGS/WAYS constants derived from the global defines.
- Sub-module rrat: holds RRAT and arch_used. It performs the intra-bundle same-ARN forwarding and emits the old-PRN list and push mask.
- free_list keeps the FIFO, count and FSM.

Test Plan:
- Reset with WAYS=2, PRF=64, REGS=32 -> num_avail=32, free_PRN={32,33}, free_valid=2'b11, rrat_out[i]=i, recovering=0.
- alloc_req=2'b11 for one cycle -> next cycle num_avail=30, free_PRN={34,35}.
- Same-ARN bundle: after that allocation, commit lane0 (ARN5,PRN32) and lane1 (ARN5,PRN33) -> pushes 5 then 32 in order, rrat_out[5]=33, num_avail 30->32; drain with pops until PRN 5 is presented, then 32.
- Simultaneous: alloc_req=2'b11 plus one commit (ARN7,PRN36) -> num_avail decrements by exactly 1; the freed PRN 7 is not presented that cycle.
- Nuke: proc_nuke=1 with lane0 commit (ARN3,PRN40), lane1 alloc_req set -> the pop is ignored, recovering=1 for 64 cycles with free_valid=0; then num_avail=32, rrat_out[3]=40, the list contains 3 and excludes 40, in ascending order.
- Wrap and empty:
  - Allocate until num_avail=0 -> free_valid=0.
  - Alternate 100 cycles of 2 pops and 2 commits -> pointers wrap past 64 with no PRN duplicated or lost (scoreboard of all 64 PRNs).
  - Assert reset mid-RECOVER -> immediate reset values.

Source files
------------

// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared constants and types for the physical-register free list and its
// retirement map (RRAT).
//   WAYS  : superscalar width (dispatch and commit lanes)
//   PRF   : number of physical registers (power of two)
//   REGS  : number of architectural registers
//   prn_t : physical register index, arn_t : architectural register index
//   cnt_t : pointer / occupancy width, one bit wider than prn_t
// -----------------------------------------------------------------------------
`ifndef WAYS
`define WAYS 2
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef REGS
`define REGS 32
`endif

package free_list_pkg;

   localparam int WAYS  = `WAYS;
   localparam int PRF   = `PRF;
   localparam int REGS  = `REGS;
   localparam int PRN_W = $clog2(PRF);
   localparam int CNT_W = PRN_W + 1;
   localparam int ARN_W = 5;

   typedef logic [PRN_W-1:0] prn_t;
   typedef logic [ARN_W-1:0] arn_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } fl_state_e;

   // Number of set lanes in a WAYS-wide mask.
   function automatic cnt_t popcount(input logic [WAYS-1:0] v);
      cnt_t n;
      n = '0;
      for (int i = 0; i < WAYS; i++) begin
         n = n + cnt_t'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/free_list_if.sv
// -----------------------------------------------------------------------------
// free_list_if
// Bundles the dispatch (allocation), commit and recovery signals of the free
// list.
//   slave  : the free list itself
//   master : the rename/dispatch + ROB side driving it
// Signals:
//   alloc_req    lanes consuming free_PRN this cycle (contiguous from lane 0)
//   free_PRN     candidate free PRNs, free_valid marks the usable lanes
//   num_avail    current free count (0 while recovering)
//   commit_*     committed register-writing instructions from the ROB
//   proc_nuke    mispredict flush, recovering = rebuild in progress
//   rrat_out     committed ARN->PRN map
// -----------------------------------------------------------------------------
interface free_list_if;
   import free_list_pkg::*;

   logic [WAYS-1:0]  alloc_req;
   prn_t [WAYS-1:0]  free_PRN;
   logic [WAYS-1:0]  free_valid;
   cnt_t             num_avail;
   logic [WAYS-1:0]  commit_valid;
   arn_t [WAYS-1:0]  commit_ARN;
   prn_t [WAYS-1:0]  commit_PRN;
   logic             proc_nuke;
   logic             recovering;
   prn_t [REGS-1:0]  rrat_out;

   modport slave (
      input  alloc_req, commit_valid, commit_ARN, commit_PRN, proc_nuke,
      output free_PRN, free_valid, num_avail, recovering, rrat_out
   );

   modport master (
      output alloc_req, commit_valid, commit_ARN, commit_PRN, proc_nuke,
      input  free_PRN, free_valid, num_avail, recovering, rrat_out
   );

endinterface

// File: rtl/free_list_rrat.sv
// -----------------------------------------------------------------------------
// free_list_rrat
// Retirement map (ARN->PRN) plus a bitmask of PRNs currently held by it.
// For each committing lane it finds the PRN being overwritten, forwarding
// from earlier lanes of the same bundle that write the same ARN.
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   commit_en_i         commits are applied only when set
//   commit_valid_i      per-lane commit valid
//   commit_arn_i/prn_i  per-lane destination ARN / new PRN
//   old_prn_o           per-lane overwritten PRN (to be freed)
//   push_mask_o         lanes whose old_prn_o must be pushed to the free list
//   rrat_o              registered map
//   arch_used_o         registered set of PRNs held by the map
// -----------------------------------------------------------------------------
module free_list_rrat
   import free_list_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              commit_en_i,
   input  logic [WAYS-1:0]   commit_valid_i,
   input  arn_t [WAYS-1:0]   commit_arn_i,
   input  prn_t [WAYS-1:0]   commit_prn_i,
   output prn_t [WAYS-1:0]   old_prn_o,
   output logic [WAYS-1:0]   push_mask_o,
   output prn_t [REGS-1:0]   rrat_o,
   output logic [PRF-1:0]    arch_used_o
);

   prn_t [REGS-1:0] rrat_q, rrat_d;
   logic [PRF-1:0]  used_q, used_d;
   logic [WAYS-1:0] lane_en;

   assign lane_en     = commit_en_i ? commit_valid_i : '0;
   assign push_mask_o = lane_en;
   assign rrat_o      = rrat_q;
   assign arch_used_o = used_q;

   // The youngest earlier lane writing the same ARN supplies the old PRN;
   // scanning j upward lets later matches override earlier ones.
   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         old_prn_o[i] = rrat_q[commit_arn_i[i]];
         for (int j = 0; j < i; j++) begin
            if (lane_en[j] && (commit_arn_i[j] == commit_arn_i[i])) begin
               old_prn_o[i] = commit_prn_i[j];
            end
         end
      end
   end

   // Lane order matters: a later lane's old PRN may be an earlier lane's new
   // PRN, so the clear must follow the earlier set.
   always_comb begin
      rrat_d = rrat_q;
      used_d = used_q;
      for (int i = 0; i < WAYS; i++) begin
         if (lane_en[i]) begin
            used_d[old_prn_o[i]]    = 1'b0;
            used_d[commit_prn_i[i]] = 1'b1;
            rrat_d[commit_arn_i[i]] = commit_prn_i[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < REGS; r++) begin
            rrat_q[r] <= prn_t'(r);
         end
         for (int p = 0; p < PRF; p++) begin
            used_q[p] <= (p < REGS);
         end
      end else begin
         rrat_q <= rrat_d;
         used_q <= used_d;
      end
   end

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Physical-register free list with integrated retirement map. Supplies up to
// WAYS free PRNs per cycle to dispatch, reclaims overwritten PRNs at commit,
// and after a nuke rebuilds the list by scanning all PRNs not held by the
// retirement map (one PRN per cycle, PRF cycles).
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   fl     free_list_if.slave (allocation, commit, nuke, map export)
// -----------------------------------------------------------------------------
module free_list
   import free_list_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   free_list_if.slave   fl
);

   fl_state_e       state_q, state_d;
   cnt_t            head_q, head_d;
   cnt_t            tail_q, tail_d;
   cnt_t            count_q, count_d;
   cnt_t            scan_q, scan_d;
   prn_t            buf_q [PRF];

   logic            normal;
   logic [WAYS-1:0] pop_mask;
   cnt_t            pops, pushes;
   prn_t [WAYS-1:0] old_prn;
   logic [WAYS-1:0] push_mask;
   prn_t [WAYS-1:0] wr_idx;
   logic [PRF-1:0]  arch_used;
   prn_t            scan_prn;

   // Pointers live in the low PRN_W bits; the top bit is kept clear.
   function automatic cnt_t wrap_ptr(input cnt_t v);
      return {1'b0, v[PRN_W-1:0]};
   endfunction

   assign normal   = (state_q == NORMAL);
   assign scan_prn = scan_q[PRN_W-1:0];

   free_list_rrat u_rrat (
      .clock          (clock),
      .reset          (reset),
      .commit_en_i    (normal),
      .commit_valid_i (fl.commit_valid),
      .commit_arn_i   (fl.commit_ARN),
      .commit_prn_i   (fl.commit_PRN),
      .old_prn_o      (old_prn),
      .push_mask_o    (push_mask),
      .rrat_o         (fl.rrat_out),
      .arch_used_o    (arch_used)
   );

   // Zero-cycle read of the next WAYS entries from head.
   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         fl.free_PRN[i]   = buf_q[head_q[PRN_W-1:0] + prn_t'(i)];
         fl.free_valid[i] = normal && (count_q > cnt_t'(i));
      end
   end

   assign fl.num_avail  = normal ? count_q : '0;
   assign fl.recovering = !normal;

   // Pushes are packed: each valid lane writes at tail plus its rank.
   always_comb begin
      prn_t off;
      off = '0;
      for (int i = 0; i < WAYS; i++) begin
         wr_idx[i] = tail_q[PRN_W-1:0] + off;
         off       = off + prn_t'(push_mask[i]);
      end
   end

   assign pop_mask = normal ? (fl.alloc_req & fl.free_valid) : '0;
   assign pops     = popcount(pop_mask);
   assign pushes   = popcount(push_mask);

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      scan_d  = scan_q;
      case (state_q)
         NORMAL: begin
            if (fl.proc_nuke) begin
               // Commits of this cycle still reach the map; the list itself
               // is discarded and rebuilt from the map.
               head_d  = '0;
               tail_d  = '0;
               count_d = '0;
               scan_d  = '0;
               state_d = RECOVER;
            end else begin
               head_d  = wrap_ptr(head_q + pops);
               tail_d  = wrap_ptr(tail_q + pushes);
               count_d = count_q - pops + pushes;
            end
         end
         RECOVER: begin
            if (!arch_used[scan_prn]) begin
               tail_d  = wrap_ptr(tail_q + cnt_t'(1));
               count_d = count_q + cnt_t'(1);
            end
            scan_d = scan_q + cnt_t'(1);
            if (scan_q == cnt_t'(PRF - 1)) begin
               state_d = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= NORMAL;
         head_q  <= '0;
         tail_q  <= cnt_t'(PRF - REGS);
         count_q <= cnt_t'(PRF - REGS);
         scan_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         scan_q  <= scan_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < PRF; p++) begin
            buf_q[p] <= prn_t'(p + REGS);
         end
      end else if (normal) begin
         for (int i = 0; i < WAYS; i++) begin
            if (push_mask[i]) begin
               buf_q[wr_idx[i]] <= old_prn[i];
            end
         end
      end else if (!arch_used[scan_prn]) begin
         buf_q[tail_q[PRN_W-1:0]] <= scan_prn;
      end
   end

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
// Randomised and directed stimulus for free_list, checked every cycle against
// a queue-based reference model (free queue + ARN map + recovery countdown).
// -----------------------------------------------------------------------------
module tb_free_list;
   import free_list_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   free_list_if fl_if ();

   free_list dut (
      .clock (clock),
      .reset (reset),
      .fl    (fl_if)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state
   int free_q[$];
   int inflight[$];
   int m_rrat[REGS];
   int rec_cnt = 0;

   task automatic check_eq(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      free_q.delete();
      inflight.delete();
      for (int p = REGS; p < PRF; p++) free_q.push_back(p);
      for (int r = 0; r < REGS; r++) m_rrat[r] = r;
      rec_cnt = 0;
   endfunction

   // After recovery the list is every PRN not mapped, ascending.
   function automatic void model_rebuild();
      bit mapped [PRF];
      for (int p = 0; p < PRF; p++) mapped[p] = 1'b0;
      for (int r = 0; r < REGS; r++) mapped[m_rrat[r]] = 1'b1;
      free_q.delete();
      for (int p = 0; p < PRF; p++) if (!mapped[p]) free_q.push_back(p);
   endfunction

   function automatic void model_step(input logic [WAYS-1:0] alloc,
                                      input logic [WAYS-1:0] cv,
                                      input arn_t [WAYS-1:0] arn,
                                      input prn_t [WAYS-1:0] prn,
                                      input logic nuke);
      if (rec_cnt > 0) begin
         rec_cnt--;
         if (rec_cnt == 0) model_rebuild();
      end else begin
         if (!nuke) begin
            for (int i = 0; i < WAYS; i++) if (alloc[i]) void'(free_q.pop_front());
         end
         for (int i = 0; i < WAYS; i++) begin
            if (cv[i]) begin
               int old;
               old = m_rrat[arn[i]];
               m_rrat[arn[i]] = int'(prn[i]);
               free_q.push_back(old);
            end
         end
         if (nuke) begin
            free_q.delete();
            rec_cnt = PRF;
         end
      end
   endfunction

   task automatic check_outputs();
      logic [255:0] exp_r;
      exp_r = '0;
      check_eq("recovering", 256'(fl_if.recovering), 256'(rec_cnt > 0));
      if (rec_cnt > 0) begin
         check_eq("num_avail_rec", 256'(fl_if.num_avail), 256'(0));
         check_eq("free_valid_rec", 256'(fl_if.free_valid), 256'(0));
      end else begin
         check_eq("num_avail", 256'(fl_if.num_avail), 256'(free_q.size()));
         for (int i = 0; i < WAYS; i++) begin
            check_eq($sformatf("free_valid[%0d]", i), 256'(fl_if.free_valid[i]),
                     256'(i < free_q.size()));
            if (i < free_q.size())
               check_eq($sformatf("free_PRN[%0d]", i), 256'(fl_if.free_PRN[i]),
                        256'(free_q[i]));
         end
      end
      for (int r = 0; r < REGS; r++) exp_r[r*PRN_W +: PRN_W] = prn_t'(m_rrat[r]);
      check_eq("rrat_out", 256'(fl_if.rrat_out), exp_r);
   endtask

   // One clock transaction: check outputs and drive at negedge, advance the
   // model at posedge, release inputs just after.
   task automatic drive_cycle(input logic [WAYS-1:0] alloc, input logic [WAYS-1:0] cv,
                              input arn_t [WAYS-1:0] arn, input prn_t [WAYS-1:0] prn,
                              input logic nuke);
      bit was_normal;
      @(negedge clock);
      check_outputs();
      was_normal = (rec_cnt == 0);
      if (was_normal && !nuke) begin
         for (int i = 0; i < WAYS; i++)
            if (alloc[i]) inflight.push_back(int'(fl_if.free_PRN[i]));
      end
      fl_if.alloc_req    = alloc;
      fl_if.commit_valid = cv;
      fl_if.commit_ARN   = arn;
      fl_if.commit_PRN   = prn;
      fl_if.proc_nuke    = nuke;
      if (fl_if.recovering)
         assert (cv == '0 && !nuke) else $error("commit or nuke driven during recovery");
      else
         assert ((alloc & ~fl_if.free_valid) == '0) else $error("alloc_req beyond free_valid");
      $display("[TB] cyc %0d alloc=%b commit=%b nuke=%b avail=%0d rec=%0d",
               cyc, alloc, cv, nuke, fl_if.num_avail, fl_if.recovering);
      cyc++;
      @(posedge clock);
      model_step(alloc, cv, arn, prn, nuke);
      if (nuke && was_normal) inflight.delete();
      #1;
      fl_if.alloc_req    = '0;
      fl_if.commit_valid = '0;
      fl_if.proc_nuke    = 1'b0;
   endtask

   task automatic idle();
      drive_cycle('0, '0, '0, '0, 1'b0);
   endtask

   // full=1 uses every available pop lane and commits on every lane it can.
   task automatic rand_cycle(input bit do_pop, input bit do_commit,
                             input bit do_nuke, input bit full);
      logic [WAYS-1:0] al;
      logic [WAYS-1:0] cv;
      arn_t [WAYS-1:0] a;
      prn_t [WAYS-1:0] p;
      logic            nk;
      int              lim;
      int              npop;
      al = '0; cv = '0; a = '0; p = '0; nk = 1'b0;
      if (rec_cnt > 0) begin
         idle();
         return;
      end
      if (do_pop) begin
         lim  = (free_q.size() < WAYS) ? free_q.size() : WAYS;
         npop = full ? lim : int'($urandom_range(0, lim));
         for (int i = 0; i < WAYS; i++) al[i] = (i < npop);
      end
      if (do_commit) begin
         for (int i = 0; i < WAYS; i++) begin
            if ((full || $urandom_range(0, 3) != 0) && inflight.size() > 0) begin
               cv[i] = 1'b1;
               p[i]  = prn_t'(inflight.pop_front());
               a[i]  = (i > 0 && $urandom_range(0, 3) == 0) ? a[0]
                                                            : arn_t'($urandom_range(0, REGS - 1));
            end
         end
      end
      if (do_nuke) nk = ($urandom_range(0, 49) == 0);
      drive_cycle(al, cv, a, p, nk);
   endtask

   initial begin
      arn_t [WAYS-1:0] a;
      prn_t [WAYS-1:0] p;
      int              seen [PRF];
      int              nbad;

      fl_if.alloc_req    = '0;
      fl_if.commit_valid = '0;
      fl_if.commit_ARN   = '0;
      fl_if.commit_PRN   = '0;
      fl_if.proc_nuke    = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      check_eq("rst_num_avail", 256'(fl_if.num_avail), 256'(PRF - REGS));
      check_eq("rst_free_valid", 256'(fl_if.free_valid), 256'({WAYS{1'b1}}));
      check_eq("rst_recovering", 256'(fl_if.recovering), 256'(0));
      for (int i = 0; i < WAYS; i++)
         check_eq($sformatf("rst_free_PRN[%0d]", i), 256'(fl_if.free_PRN[i]), 256'(REGS + i));
      for (int r = 0; r < REGS; r++)
         check_eq($sformatf("rst_rrat[%0d]", r), 256'(fl_if.rrat_out[r]), 256'(r));

      // Two-lane allocation
      drive_cycle(2'b11, '0, '0, '0, 1'b0);
      check_eq("alloc_num_avail", 256'(fl_if.num_avail), 256'(30));
      check_eq("alloc_free_PRN0", 256'(fl_if.free_PRN[0]), 256'(34));
      check_eq("alloc_free_PRN1", 256'(fl_if.free_PRN[1]), 256'(35));

      // Same-ARN bundle: frees 5 then 32
      a[0] = 5'd5;  a[1] = 5'd5;  p[0] = prn_t'(32); p[1] = prn_t'(33);
      drive_cycle('0, 2'b11, a, p, 1'b0);
      check_eq("sameARN_num_avail", 256'(fl_if.num_avail), 256'(32));
      check_eq("sameARN_rrat5", 256'(fl_if.rrat_out[5]), 256'(33));

      // Pop two while one commit frees PRN 7
      a[0] = 5'd7;  a[1] = '0;  p[0] = prn_t'(36); p[1] = '0;
      drive_cycle(2'b11, 2'b01, a, p, 1'b0);
      check_eq("simul_num_avail", 256'(fl_if.num_avail), 256'(31));
      check_eq("simul_free_PRN0", 256'(fl_if.free_PRN[0]), 256'(36));

      // Drain to the reclaimed entries
      repeat (14) drive_cycle(2'b11, '0, '0, '0, 1'b0);
      check_eq("drain_free_PRN0", 256'(fl_if.free_PRN[0]), 256'(5));
      check_eq("drain_free_PRN1", 256'(fl_if.free_PRN[1]), 256'(32));

      // Nuke with a commit in the same cycle; pop is ignored
      a[0] = 5'd3;  p[0] = prn_t'(40);
      drive_cycle(2'b11, 2'b01, a, p, 1'b1);
      repeat (PRF) idle();
      check_eq("nuke_num_avail", 256'(fl_if.num_avail), 256'(PRF - REGS));
      check_eq("nuke_rrat3", 256'(fl_if.rrat_out[3]), 256'(40));
      check_eq("nuke_free_PRN0", 256'(fl_if.free_PRN[0]), 256'(3));
      check_eq("nuke_free_PRN1", 256'(fl_if.free_PRN[1]), 256'(5));

      // Allocate everything (order checked by model against ascending list)
      while (free_q.size() > 0) rand_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("empty_free_valid", 256'(fl_if.free_valid), 256'(0));
      check_eq("empty_num_avail", 256'(fl_if.num_avail), 256'(0));

      // Alternate full commits and full pops: pointers wrap past PRF
      for (int c = 0; c < 100; c++) rand_cycle(c % 2 == 1, c % 2 == 0, 1'b0, 1'b1);

      // Random traffic with occasional nukes
      for (int c = 0; c < 400; c++) rand_cycle(1'b1, 1'b1, 1'b1, 1'b0);

      // Scoreboard: every PRN is exactly in one of map / in-flight / drained
      while (rec_cnt > 0) idle();
      while (free_q.size() > 0) rand_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
      for (int q = 0; q < PRF; q++) seen[q] = 0;
      for (int r = 0; r < REGS; r++) seen[fl_if.rrat_out[r]]++;
      foreach (inflight[k]) seen[inflight[k]]++;
      nbad = 0;
      for (int q = 0; q < PRF; q++) if (seen[q] != 1) nbad++;
      check_eq("scoreboard_bad_prns", 256'(nbad), 256'(0));

      // Reset in the middle of recovery
      drive_cycle('0, '0, '0, '0, 1'b1);
      repeat (10) idle();
      #2 reset = 1'b0;
      #1;
      check_eq("midrst_recovering", 256'(fl_if.recovering), 256'(0));
      check_eq("midrst_num_avail", 256'(fl_if.num_avail), 256'(PRF - REGS));
      check_eq("midrst_free_PRN0", 256'(fl_if.free_PRN[0]), 256'(REGS));
      check_eq("midrst_free_PRN1", 256'(fl_if.free_PRN[1]), 256'(REGS + 1));
      check_eq("midrst_free_valid", 256'(fl_if.free_valid), 256'({WAYS{1'b1}}));
      model_reset();
      check_outputs();
      @(negedge clock);
      reset = 1'b1;
      repeat (4) rand_cycle(1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
